// File: rtl/spi_pkg.sv
// Shared SPI frame constants, register map and controller state encoding.
// The register peripheral imports the same package so both ends agree on the address map.
package spi_pkg;

   localparam int FRAME_BITS = 16;
   localparam logic RW_WRITE = 1'b1;

   localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
   localparam logic [6:0] ADDR_PWM_DUTY  = 7'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } ctrlState_t;

   function automatic logic [FRAME_BITS-1:0] packFrame(input logic rw,
                                                      input logic [6:0] addr,
                                                      input logic [7:0] data);
      return {rw, addr, data};
   endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request handshake plus 3-wire SPI bus of the controller.
// master = the requesting logic, slave = the spi_controller itself.
interface spi_controller_if;

   logic       req_valid;
   logic       req_ready;
   logic       req_rw;
   logic [6:0] req_addr;
   logic [7:0] req_data;
   logic       SCLK;
   logic       COPI;
   logic       nCS;
   logic       busy;
   logic       done;

   modport master (
      output req_valid, req_rw, req_addr, req_data,
      input  req_ready, SCLK, COPI, nCS, busy, done
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_data,
      output req_ready, SCLK, COPI, nCS, busy, done
   );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK half-period generator: idles low while disabled, toggles every CLK_DIV clocks when enabled.
// Strobes flag the clock edge on which SCLK is about to rise or fall.
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_enable,
   output logic o_sclk,
   output logic o_rise,
   output logic o_fall
);

   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

   logic [7:0] r_halfCnt;
   logic       r_level;
   logic       w_phaseEnd;

   assign w_phaseEnd = i_enable && (r_halfCnt == HALF_LAST);
   assign o_rise     = w_phaseEnd && !r_level;
   assign o_fall     = w_phaseEnd && r_level;
   assign o_sclk     = r_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halfCnt <= '0;
         r_level   <= 1'b0;
      end else if (!i_enable) begin
         r_halfCnt <= '0;
         r_level   <= 1'b0;
      end else if (w_phaseEnd) begin
         r_halfCnt <= '0;
         r_level   <= ~r_level;
      end else begin
         r_halfCnt <= r_halfCnt + 8'd1;
      end
   end

endmodule

// File: rtl/spi_controller.sv
// SPI initiator: accepts one register-write request per handshake and sends it as a
// 16-bit mode-0 frame on SCLK/COPI/nCS, pulsing done as nCS releases.
module spi_controller #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_controller_if.slave  bus
);

   import spi_pkg::*;

   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CLK_DIV - 1);
   localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);
   localparam logic [4:0] LAST_EDGE  = 5'(FRAME_BITS);

   ctrlState_t                r_state;
   logic [FRAME_BITS-2:0]     r_shiftReg;
   logic [7:0]                r_phaseCnt;
   logic [4:0]                r_edgeCnt;
   logic                      r_copi;
   logic                      r_nCs;
   logic                      r_done;
   logic [FRAME_BITS-1:0]     w_frame;
   logic                      w_shiftEn;
   logic                      w_sclk;
   logic                      w_rise;
   logic                      w_fall;

   assign w_frame   = packFrame(bus.req_rw, bus.req_addr, bus.req_data);
   assign w_shiftEn = (r_state == ST_SHIFT);

   assign bus.req_ready = (r_state == ST_IDLE);
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.SCLK      = w_sclk;
   assign bus.COPI      = r_copi;
   assign bus.nCS       = r_nCs;
   assign bus.done      = r_done;

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclkGen (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_enable (w_shiftEn),
      .o_sclk   (w_sclk),
      .o_rise   (w_rise),
      .o_fall   (w_fall)
   );

   // Bit 15 goes straight to COPI at acceptance; the shift register holds the remaining 15 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_shiftReg <= '0;
         r_phaseCnt <= '0;
         r_edgeCnt  <= '0;
         r_copi     <= 1'b0;
         r_nCs      <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_state    <= ST_SETUP;
                  r_nCs      <= 1'b0;
                  r_copi     <= w_frame[FRAME_BITS-1];
                  r_shiftReg <= w_frame[FRAME_BITS-2:0];
                  r_phaseCnt <= '0;
                  r_edgeCnt  <= '0;
               end
            end
            ST_SETUP: begin
               if (r_phaseCnt == SETUP_LAST) begin
                  r_phaseCnt <= '0;
                  r_state    <= ST_SHIFT;
               end else begin
                  r_phaseCnt <= r_phaseCnt + 8'd1;
               end
            end
            // Edge counter counts high phases; the fall ending the 16th one closes the frame.
            ST_SHIFT: begin
               if (w_rise) begin
                  r_edgeCnt <= r_edgeCnt + 5'd1;
               end
               if (w_fall) begin
                  if (r_edgeCnt == LAST_EDGE) begin
                     r_state <= ST_HOLD;
                     r_copi  <= 1'b0;
                  end else begin
                     r_copi     <= r_shiftReg[FRAME_BITS-2];
                     r_shiftReg <= {r_shiftReg[FRAME_BITS-3:0], 1'b0};
                  end
               end
            end
            ST_HOLD: begin
               if (r_phaseCnt == HOLD_LAST) begin
                  r_phaseCnt <= '0;
                  r_nCs      <= 1'b1;
                  r_done     <= 1'b1;
                  r_state    <= ST_GAP;
               end else begin
                  r_phaseCnt <= r_phaseCnt + 8'd1;
               end
            end
            ST_GAP: begin
               if (r_phaseCnt == IDLE_LAST) begin
                  r_phaseCnt <= '0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_phaseCnt <= r_phaseCnt + 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_nCs   <= 1'b1;
               r_copi  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (default timing and CLK_DIV=7/CS_SETUP=5) observed
// by a bus monitor that rebuilds each frame and its timing, compared against arithmetic expectations.
module tb_spi_controller;

   import spi_pkg::*;

   localparam int A_DIV = 4, A_SETUP = 2, A_IDLE = 2;
   localparam int B_DIV = 7, B_SETUP = 5, B_IDLE = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       valid = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = '0;
   logic [7:0] data = '0;

   always #5 clk = ~clk;

   spi_controller_if ifA ();
   spi_controller_if ifB ();

   assign ifA.req_valid = valid & ~sel;
   assign ifA.req_rw    = rw;
   assign ifA.req_addr  = addr;
   assign ifA.req_data  = data;
   assign ifB.req_valid = valid & sel;
   assign ifB.req_rw    = rw;
   assign ifB.req_addr  = addr;
   assign ifB.req_data  = data;

   spi_controller #(.CLK_DIV(A_DIV), .CS_SETUP(A_SETUP), .CS_IDLE(A_IDLE))
      dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
   spi_controller #(.CLK_DIV(B_DIV), .CS_SETUP(B_SETUP), .CS_IDLE(B_IDLE))
      dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

   wire mSclk  = sel ? ifB.SCLK      : ifA.SCLK;
   wire mCopi  = sel ? ifB.COPI      : ifA.COPI;
   wire mNcs   = sel ? ifB.nCS       : ifA.nCS;
   wire mBusy  = sel ? ifB.busy      : ifA.busy;
   wire mDone  = sel ? ifB.done      : ifA.done;
   wire mReady = sel ? ifB.req_ready : ifA.req_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] frame;
      int rises, csLen, setupToRise, minHigh, maxHigh, minLow, maxLow, gap;
   } frameRec_t;

   frameRec_t frameQ[$];
   int        hsQ[$];
   frameRec_t cur;
   int  cycle = 0, sinceFall = 0, runLen = 0, lastCsRise = 0;
   int  doneTotal = 0, doneMisaligned = 0, copiViol = 0;
   bit  inFrame = 0;
   logic prevSclk = 1'b0, prevNcs = 1'b1, prevCopi = 1'b0;
   bit  sRise, sFall, cFall, cRise;

   // Bus monitor: samples on the falling clock edge and rebuilds each frame from the wires alone.
   always @(negedge clk) begin
      cycle++;
      if (!rst_n) begin
         inFrame = 0;
      end else begin
         sRise = !prevSclk && mSclk;
         sFall = prevSclk && !mSclk;
         cFall = prevNcs && !mNcs;
         cRise = !prevNcs && mNcs;
         if (valid && mReady) hsQ.push_back(cycle);
         if (mDone) begin
            doneTotal++;
            if (!cRise) doneMisaligned++;
         end
         if (mCopi !== prevCopi && !sFall && !cFall) copiViol++;
         if (cFall) begin
            inFrame = 1;
            cur.frame = '0;
            cur.rises = 0;
            cur.csLen = 1;
            cur.setupToRise = -1;
            cur.minHigh = 9999; cur.maxHigh = 0;
            cur.minLow = 9999;  cur.maxLow = 0;
            cur.gap = cycle - lastCsRise;
            sinceFall = 0;
            runLen = 0;
         end else if (inFrame) begin
            sinceFall++;
            if (!mNcs) cur.csLen++;
            if (sRise) begin
               cur.frame = {cur.frame[14:0], mCopi};
               cur.rises++;
               if (cur.rises == 1) cur.setupToRise = sinceFall;
               else begin
                  if (runLen < cur.minLow) cur.minLow = runLen;
                  if (runLen > cur.maxLow) cur.maxLow = runLen;
               end
               runLen = 1;
            end else if (sFall) begin
               if (runLen < cur.minHigh) cur.minHigh = runLen;
               if (runLen > cur.maxHigh) cur.maxHigh = runLen;
               runLen = 1;
            end else begin
               runLen++;
            end
         end
         if (cRise) begin
            lastCsRise = cycle;
            if (inFrame) begin
               frameQ.push_back(cur);
               inFrame = 0;
            end
         end
      end
      prevSclk = mSclk;
      prevNcs  = mNcs;
      prevCopi = mCopi;
   end

   task automatic applyStimulus(input logic r, input logic [6:0] a, input logic [7:0] d);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      valid = 1'b1; rw = r; addr = a; data = d;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (mReady) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      valid = 1'b0;
      addr = ~a;
      data = ~d;
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL handshake: ready never seen, got 0 required 1");
      end
   endtask

   task automatic waitFrame(output frameRec_t rec, output bit ok);
      ok = 0;
      for (int i = 0; i < 3000 && frameQ.size() == 0; i++) @(negedge clk);
      checks++;
      if (frameQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL frameTimeout: frames seen 0 required 1");
         rec.frame = 'x;
      end else begin
         rec = frameQ.pop_front();
         ok = 1;
      end
      for (int i = 0; i < 100 && !mReady; i++) @(negedge clk);
   endtask

   function automatic logic [15:0] expFrame(input int r, input int a, input int d);
      return 16'(r * 32768 + a * 256 + d);
   endfunction

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks += 7;
      if (ifA.SCLK !== 1'b0)      begin errors++; $display("[TB] FAIL resetSclk: got %b required 0", ifA.SCLK); end
      if (ifA.COPI !== 1'b0)      begin errors++; $display("[TB] FAIL resetCopi: got %b required 0", ifA.COPI); end
      if (ifA.nCS !== 1'b1)       begin errors++; $display("[TB] FAIL resetNcs: got %b required 1", ifA.nCS); end
      if (ifA.busy !== 1'b0)      begin errors++; $display("[TB] FAIL resetBusy: got %b required 0", ifA.busy); end
      if (ifA.done !== 1'b0)      begin errors++; $display("[TB] FAIL resetDone: got %b required 0", ifA.done); end
      if (ifA.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL resetReady: got %b required 1", ifA.req_ready); end
      if (ifB.nCS !== 1'b1)       begin errors++; $display("[TB] FAIL resetNcsB: got %b required 1", ifB.nCS); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_single_frame;
      frameRec_t rec;
      bit ok;
      int doneBefore;
      doneBefore = doneTotal;
      applyStimulus(1'b1, 7'h00, 8'hF0);
      waitFrame(rec, ok);
      if (ok) begin
         checks += 5;
         if (rec.frame !== 16'h80F0) begin errors++; $display("[TB] FAIL singleFrame: got %h required 80f0", rec.frame); end
         if (rec.rises != 16) begin errors++; $display("[TB] FAIL singleRises: got %0d required 16", rec.rises); end
         if (rec.csLen != A_SETUP + 33 * A_DIV) begin errors++; $display("[TB] FAIL singleCsLen: got %0d required %0d", rec.csLen, A_SETUP + 33 * A_DIV); end
         if (rec.setupToRise != A_SETUP + A_DIV) begin errors++; $display("[TB] FAIL firstRise: got %0d required %0d", rec.setupToRise, A_SETUP + A_DIV); end
         if (doneTotal - doneBefore != 1) begin errors++; $display("[TB] FAIL doneCount: got %0d required 1", doneTotal - doneBefore); end
      end
      checks++;
      if (mBusy !== 1'b0) begin errors++; $display("[TB] FAIL busyAfter: got %b required 0", mBusy); end
   endtask

   task automatic test_random_frames;
      frameRec_t rec;
      bit ok;
      int r, a, d;
      for (int n = 0; n < 6; n++) begin
         r = $urandom_range(0, 1);
         a = $urandom_range(0, 127);
         d = $urandom_range(0, 255);
         applyStimulus(1'(r), 7'(a), 8'(d));
         waitFrame(rec, ok);
         if (ok) begin
            checks += 3;
            if (rec.frame !== expFrame(r, a, d)) begin errors++; $display("[TB] FAIL randFrame%0d: got %h required %h", n, rec.frame, expFrame(r, a, d)); end
            if (rec.csLen != A_SETUP + 33 * A_DIV) begin errors++; $display("[TB] FAIL randCsLen%0d: got %0d required %0d", n, rec.csLen, A_SETUP + 33 * A_DIV); end
            if (rec.minHigh != A_DIV || rec.maxHigh != A_DIV || rec.minLow != A_DIV || rec.maxLow != A_DIV) begin
               errors++;
               $display("[TB] FAIL randPhase%0d: got high %0d..%0d low %0d..%0d required %0d", n, rec.minHigh, rec.maxHigh, rec.minLow, rec.maxLow, A_DIV);
            end
         end
      end
   endtask

   task automatic test_rw_zero;
      frameRec_t rec;
      bit ok;
      applyStimulus(1'b0, 7'h02, 8'h55);
      waitFrame(rec, ok);
      if (ok) begin
         checks++;
         if (rec.frame !== 16'h0255) begin errors++; $display("[TB] FAIL rwZero: got %h required 0255", rec.frame); end
      end
   endtask

   task automatic test_back_to_back;
      frameRec_t rec1, rec2;
      bit ok1, ok2;
      int a1, d1, a2, d2;
      a1 = $urandom_range(0, 127); d1 = $urandom_range(0, 255);
      a2 = $urandom_range(0, 127); d2 = $urandom_range(0, 255);
      hsQ.delete();
      @(posedge clk); #1;
      valid = 1'b1; rw = RW_WRITE; addr = 7'(a1); data = 8'(d1);
      for (int i = 0; i < 2000 && hsQ.size() < 1; i++) @(negedge clk);
      @(posedge clk); #1;
      addr = 7'(a2); data = 8'(d2);
      for (int i = 0; i < 2000 && hsQ.size() < 2; i++) @(negedge clk);
      @(posedge clk); #1;
      valid = 1'b0;
      checks++;
      if (hsQ.size() < 2) begin
         errors++;
         $display("[TB] FAIL b2bHandshakes: got %0d required 2", hsQ.size());
      end else begin
         checks++;
         if (hsQ[1] - hsQ[0] != 1 + A_SETUP + 33 * A_DIV + A_IDLE) begin
            errors++;
            $display("[TB] FAIL b2bSpacing: got %0d required %0d", hsQ[1] - hsQ[0], 1 + A_SETUP + 33 * A_DIV + A_IDLE);
         end
      end
      waitFrame(rec1, ok1);
      waitFrame(rec2, ok2);
      if (ok1 && ok2) begin
         checks += 3;
         if (rec1.frame !== expFrame(1, a1, d1)) begin errors++; $display("[TB] FAIL b2bFrame1: got %h required %h", rec1.frame, expFrame(1, a1, d1)); end
         if (rec2.frame !== expFrame(1, a2, d2)) begin errors++; $display("[TB] FAIL b2bFrame2: got %h required %h", rec2.frame, expFrame(1, a2, d2)); end
         if (rec2.gap != A_IDLE + 1) begin errors++; $display("[TB] FAIL b2bGap: got %0d required %0d", rec2.gap, A_IDLE + 1); end
      end
   endtask

   task automatic test_reset_midframe;
      frameRec_t rec;
      bit ok;
      int doneBefore, a, d;
      doneBefore = doneTotal;
      applyStimulus(1'b1, 7'h35, 8'hA6);
      for (int i = 0; i < 2000 && !(inFrame && cur.rises >= 8); i++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (ifA.nCS !== 1'b1)       begin errors++; $display("[TB] FAIL midRstNcs: got %b required 1", ifA.nCS); end
      if (ifA.SCLK !== 1'b0)      begin errors++; $display("[TB] FAIL midRstSclk: got %b required 0", ifA.SCLK); end
      if (ifA.COPI !== 1'b0)      begin errors++; $display("[TB] FAIL midRstCopi: got %b required 0", ifA.COPI); end
      if (ifA.busy !== 1'b0)      begin errors++; $display("[TB] FAIL midRstBusy: got %b required 0", ifA.busy); end
      if (ifA.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midRstReady: got %b required 1", ifA.req_ready); end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      checks += 2;
      if (doneTotal != doneBefore) begin errors++; $display("[TB] FAIL midRstDone: got %0d pulses required 0", doneTotal - doneBefore); end
      if (frameQ.size() != 0) begin errors++; $display("[TB] FAIL midRstFrame: got %0d frames required 0", frameQ.size()); end
      a = $urandom_range(0, 127);
      d = $urandom_range(0, 255);
      applyStimulus(1'b1, 7'(a), 8'(d));
      waitFrame(rec, ok);
      if (ok) begin
         checks++;
         if (rec.frame !== expFrame(1, a, d)) begin errors++; $display("[TB] FAIL postRstFrame: got %h required %h", rec.frame, expFrame(1, a, d)); end
      end
   endtask

   task automatic test_clkdiv7;
      frameRec_t rec;
      bit ok;
      int r, a, d;
      repeat (2) @(posedge clk);
      #1;
      sel = 1'b1;
      repeat (2) @(posedge clk);
      for (int n = 0; n < 3; n++) begin
         r = $urandom_range(0, 1);
         a = $urandom_range(0, 127);
         d = $urandom_range(0, 255);
         applyStimulus(1'(r), 7'(a), 8'(d));
         waitFrame(rec, ok);
         if (ok) begin
            checks += 5;
            if (rec.frame !== expFrame(r, a, d)) begin errors++; $display("[TB] FAIL div7Frame%0d: got %h required %h", n, rec.frame, expFrame(r, a, d)); end
            if (rec.csLen != B_SETUP + 33 * B_DIV) begin errors++; $display("[TB] FAIL div7CsLen%0d: got %0d required %0d", n, rec.csLen, B_SETUP + 33 * B_DIV); end
            if (rec.minHigh != B_DIV || rec.maxHigh != B_DIV) begin errors++; $display("[TB] FAIL div7High%0d: got %0d..%0d required %0d", n, rec.minHigh, rec.maxHigh, B_DIV); end
            if (rec.minLow != B_DIV || rec.maxLow != B_DIV) begin errors++; $display("[TB] FAIL div7Low%0d: got %0d..%0d required %0d", n, rec.minLow, rec.maxLow, B_DIV); end
            if (rec.setupToRise != B_SETUP + B_DIV) begin errors++; $display("[TB] FAIL div7FirstRise%0d: got %0d required %0d", n, rec.setupToRise, B_SETUP + B_DIV); end
         end
      end
   endtask

   task automatic test_bus_rules;
      checks += 2;
      if (copiViol != 0) begin errors++; $display("[TB] FAIL copiStability: got %0d stray changes required 0", copiViol); end
      if (doneMisaligned != 0) begin errors++; $display("[TB] FAIL doneAlign: got %0d misaligned pulses required 0", doneMisaligned); end
   endtask

   initial begin
      $display("[TB] starting spi_controller bench");
      test_reset();
      test_single_frame();
      test_random_frames();
      test_rw_zero();
      test_back_to_back();
      test_reset_midframe();
      test_clkdiv7();
      test_bus_rules();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI controller (initiator) that drives the 3-wire SCLK/COPI/nCS bus consumed by the on-chip SPI register peripheral. It accepts one register-write request per valid/ready handshake, serialises it as a 16-bit mode-0 frame, and reports completion. It is used in bring-up and self-test builds to program the enable and PWM-duty registers from on-chip logic instead of external pins.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal 4..255 (≥4 guarantees the peripheral's 2-FF synchronisers see every edge).
- CS_SETUP, 2: clk cycles nCS is low before the first SCLK rising edge; legal 1..255.
- CS_IDLE, 2: clk cycles nCS stays high between frames; legal 1..255.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer on req_valid & req_ready.
- req_rw  in  1  frame bit 15 (1 = write); sent verbatim.
- req_addr  in  7  register address, frame bits 14:8.
- req_data  in  8  register data, frame bits 7:0.
- SCLK  out  1  SPI clock, idle low.
- COPI  out  1  serial data, MSB first.
- nCS  out  1  chip select, active low.
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-cycle pulse when nCS deasserts.

## Operation
- Frame = {req_rw, req_addr, req_data}, 16 bits, MSB first; SPI mode 0 (CPOL=0, CPHA=0).
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: req_ready=1, nCS=1, SCLK=0. On handshake latch frame into 16-bit shift register, go SETUP. Inputs are sampled only at handshake; later changes ignored.
- SETUP: nCS=0, COPI=frame[15], SCLK=0, CS_SETUP cycles, then SHIFT.
- SHIFT: per bit, SCLK low CLK_DIV cycles, then high CLK_DIV cycles. COPI changes only on the cycle SCLK falls (shift left, next bit); stable across every rising edge. 5-bit edge counter; after the 16th high phase SCLK falls and state goes HOLD.
- HOLD: SCLK=0, nCS=0, COPI=0, CLK_DIV cycles, then nCS=1, done=1 for that one cycle, go GAP.
- GAP: nCS=1, CS_IDLE cycles, then IDLE.
- No read-data path; req_rw=0 frames are sent unchanged and the peripheral discards them.
- Reset asserted mid-frame: all state and outputs to reset values immediately (asynchronous); partial frame abandoned, no done.

## Timing
- Reset values: SCLK=0, COPI=0, nCS=1, busy=0, done=0, req_ready=1, state IDLE.
- All outputs registered; no combinational path from inputs to SCLK/COPI/nCS/done. req_ready and busy are decoded from registered state only.
- Handshake at edge T: nCS low from T+1; first SCLK rise at T+1+CS_SETUP+CLK_DIV.
- nCS low duration = CS_SETUP + 33·CLK_DIV cycles (134 at defaults); SCLK period = 2·CLK_DIV.
- Handshake-to-handshake minimum = 1 + CS_SETUP + 33·CLK_DIV + CS_IDLE cycles (137 at defaults); req_valid held high is accepted on the first IDLE cycle after GAP.
- done asserts on the same cycle nCS rises; busy falls on the cycle entering IDLE.

## Structure
- Shared package spi_pkg: FRAME_BITS=16, RW_WRITE=1'b1, register address constants (ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_PWM_DUTY=4), controller state enum; the peripheral imports the same constants.
- One sub-module: spi_sclk_gen (half-period counter; emits rise/fall strobes and SCLK level, enabled only in SHIFT).

## Test plan
- Defaults, req {1, 0x00, 0xF0}: COPI sampled on 16 SCLK rises = 0x80F0; nCS low exactly 134 cycles; one done pulse; 16 rising edges counted.
- Loopback to spi_peripheral, write ADDR_PWM_DUTY=0x80 then ADDR_EN_OUT_LO=0xFF: peripheral pwm_duty_cycle=0x80, en_reg_out_7_0=0xFF.
- req_valid held high with two queued requests: second handshake exactly 137 cycles after first; nCS high ≥2 cycles between frames; req_data changed after handshake does not affect frame in flight.
- req_rw=0, addr 0x02, data 0x55: COPI stream 0x0255; peripheral registers unchanged.
- rst_n low at 8th SCLK rise: same cycle nCS=1, SCLK=0, COPI=0, busy=0; no done; next request after release produces a complete correct frame.
- CLK_DIV=7, CS_SETUP=5: SCLK high/low phases each 7 cycles, nCS low 5+231=236 cycles, COPI never changes within ±1 cycle of a rising edge.
